// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the shared memory block.
// Port 0 is instruction fetch, port 1 is load/store; one transaction is outstanding at a time.
module mem_arbiter #(
  parameter int unsigned MEM_ADDR_SIZE  = 32,
  parameter int unsigned MEM_WORD_SIZE  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     p0Req,
  input  logic                     p1Req,
  input  logic                     p0Wr,
  input  logic                     p1Wr,
  input  logic [MEM_ADDR_SIZE-1:0] p0Addr,
  input  logic [MEM_ADDR_SIZE-1:0] p1Addr,
  input  logic [MEM_WORD_SIZE-1:0] p0WrData,
  input  logic [MEM_WORD_SIZE-1:0] p1WrData,
  output logic                     p0Ack,
  output logic                     p1Ack,
  output logic [MEM_WORD_SIZE-1:0] p0RdData,
  output logic [MEM_WORD_SIZE-1:0] p1RdData,
  output logic [MEM_ADDR_SIZE-1:0] memAddr,
  output logic [MEM_WORD_SIZE-1:0] memDataIn,
  output logic                     memWr,
  output logic                     memReq,
  input  logic                     memBusyOut,
  input  logic [MEM_WORD_SIZE-1:0] memDataOut,
  output logic                     arbGrant,
  output logic                     arbBusy,
  output logic                     timeoutErr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_n;
  logic        lastGrant;
  logic        grant, winner, capture, toErrSet, toHit;
  logic [15:0] toCnt;

  assign toHit = (toCnt == TO_LAST);

  always_comb begin
    state_n  = state;
    grant    = 1'b0;
    winner   = lastGrant;
    capture  = 1'b0;
    toErrSet = 1'b0;
    case (state)
      IDLE: begin
        if (p0Req && p1Req) begin
          grant  = 1'b1;
          winner = ~lastGrant;
        end else if (p0Req || p1Req) begin
          grant  = 1'b1;
          winner = p1Req;
        end
        if (grant) state_n = ISSUE;
      end
      ISSUE: begin
        if (toHit) begin
          state_n  = DONE;
          toErrSet = 1'b1;
        end else if (memBusyOut) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        // Completion wins over a coincident timeout so valid read data is not dropped.
        if (!memBusyOut) begin
          state_n = DONE;
          capture = ~memWr;
        end else if (toHit) begin
          state_n  = DONE;
          toErrSet = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Every output is a register loaded from the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant  <= 1'b1;
      arbGrant   <= 1'b0;
      arbBusy    <= 1'b0;
      memReq     <= 1'b0;
      memWr      <= 1'b0;
      memAddr    <= '0;
      memDataIn  <= '0;
      p0Ack      <= 1'b0;
      p1Ack      <= 1'b0;
      p0RdData   <= '0;
      p1RdData   <= '0;
      timeoutErr <= 1'b0;
      toCnt      <= '0;
    end else begin
      memReq  <= (state_n == ISSUE);
      arbBusy <= (state_n != IDLE);
      p0Ack   <= (state_n == DONE) && !arbGrant;
      p1Ack   <= (state_n == DONE) && arbGrant;
      if (grant) begin
        arbGrant  <= winner;
        lastGrant <= winner;
        memAddr   <= winner ? p1Addr   : p0Addr;
        memDataIn <= winner ? p1WrData : p0WrData;
        memWr     <= winner ? p1Wr     : p0Wr;
        toCnt     <= '0;
      end else if (state == ISSUE || state == WAIT) begin
        toCnt <= toCnt + 16'd1;
      end
      if (toErrSet) timeoutErr <= 1'b1;
      if (capture) begin
        if (arbGrant) p1RdData <= memDataOut;
        else          p0RdData <= memDataOut;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory with selectable latency, transaction-level
// reference model (round-robin pick, shadow memory, expected read data and ack latency).
module tb_mem_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req [2];
  logic        wr  [2];
  logic [31:0] addr[2];
  logic [7:0]  wd  [2];
  logic        p0Ack, p1Ack, memWr, memReq, memBusyOut, arbGrant, arbBusy, timeoutErr;
  logic [7:0]  p0RdData, p1RdData, memDataIn, memDataOut;
  logic [31:0] memAddr;

  mem_arbiter #(.MEM_ADDR_SIZE(32), .MEM_WORD_SIZE(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .p0Req(req[0]), .p1Req(req[1]), .p0Wr(wr[0]), .p1Wr(wr[1]),
    .p0Addr(addr[0]), .p1Addr(addr[1]), .p0WrData(wd[0]), .p1WrData(wd[1]),
    .p0Ack(p0Ack), .p1Ack(p1Ack), .p0RdData(p0RdData), .p1RdData(p1RdData),
    .memAddr(memAddr), .memDataIn(memDataIn), .memWr(memWr), .memReq(memReq),
    .memBusyOut(memBusyOut), .memDataOut(memDataOut),
    .arbGrant(arbGrant), .arbBusy(arbBusy), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory stub: goes busy the edge after it sees memReq, stays busy mem_lat cycles.
  logic [7:0] init_mem[16];
  logic [7:0] mem[16];
  logic       mbusy, stuck;
  int         mcnt, mem_lat;
  assign memBusyOut = mbusy | stuck;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mbusy      <= 1'b0;
      mcnt       <= 0;
      memDataOut <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
    end else if (mbusy) begin
      if (mcnt <= 1) begin
        mbusy <= 1'b0;
        if (memWr) mem[memAddr[3:0]] <= memDataIn;
        else       memDataOut <= mem[memAddr[3:0]];
      end else begin
        mcnt <= mcnt - 1;
      end
    end else if (memReq) begin
      mbusy <= 1'b1;
      mcnt  <= mem_lat;
    end
  end

  // Reference model state
  bit         lastG;
  bit         exp_to;
  logic [7:0] exp_mem[16];
  logic [7:0] exp_rd[2];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_p0Ack"}, 32'(p0Ack), 0);
    chk({tag, "_p1Ack"}, 32'(p1Ack), 0);
    chk({tag, "_p0RdData"}, 32'(p0RdData), 0);
    chk({tag, "_p1RdData"}, 32'(p1RdData), 0);
    chk({tag, "_memAddr"}, memAddr, 0);
    chk({tag, "_memDataIn"}, 32'(memDataIn), 0);
    chk({tag, "_memWr"}, 32'(memWr), 0);
    chk({tag, "_memReq"}, 32'(memReq), 0);
    chk({tag, "_arbGrant"}, 32'(arbGrant), 0);
    chk({tag, "_arbBusy"}, 32'(arbBusy), 0);
    chk({tag, "_timeoutErr"}, 32'(timeoutErr), 0);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    stuck  = 1'b0;
    lastG  = 1'b1;
    exp_to = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    for (int i = 0; i < 16; i++) exp_mem[i] = init_mem[i];
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
  endtask

  // One whole transaction: predicts the winner, checks hold/ack/data, returns at DONE->IDLE +1.
  task automatic run_txn(input int lat, input bit scramble, output int w, output int ackcyc);
    int n, cycles, exp_lat;
    bit got;
    logic [31:0] ea;
    logic [7:0]  ed;
    logic        ewr;
    w = (req[0] && req[1]) ? int'(!lastG) : (req[0] ? 0 : 1);
    mem_lat = lat;
    ackcyc = 0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (memReq !== 1'b1 && n < 50);
    if (n >= 50) begin
      chk("grant_wait", 0, 1);
      return;
    end
    ea = addr[w]; ed = wd[w]; ewr = wr[w];
    lastG = w[0];
    chk("grant", 32'(arbGrant), 32'(w));
    chk("issue_addr", memAddr, ea);
    chk("issue_wr", 32'(memWr), 32'(ewr));
    chk("issue_data", 32'(memDataIn), 32'(ed));
    if (scramble) begin
      addr[w] = $urandom; wd[w] = 8'($urandom); wr[w] = ~wr[w];
    end
    cycles = 0;
    got = 0;
    while (!got && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      chk("hold_addr", memAddr, ea);
      chk("hold_wr", 32'(memWr), 32'(ewr));
      chk("hold_data", 32'(memDataIn), 32'(ed));
      chk("busy", 32'(arbBusy), 1);
      chk("other_ack", 32'(w == 0 ? p1Ack : p0Ack), 0);
      got = (w == 0) ? p0Ack : p1Ack;
    end
    ackcyc = cyc;
    exp_lat = stuck ? TO : lat + 2;
    chk("ack_latency", 32'(cycles), 32'(exp_lat));
    if (stuck) exp_to = 1'b1;
    else if (ewr) exp_mem[ea[3:0]] = ed;
    else exp_rd[w] = exp_mem[ea[3:0]];
    chk("p0RdData", 32'(p0RdData), 32'(exp_rd[0]));
    chk("p1RdData", 32'(p1RdData), 32'(exp_rd[1]));
    chk("done_memReq", 32'(memReq), 0);
    chk("timeoutErr", 32'(timeoutErr), 32'(exp_to));
    @(posedge clk); #1;
    chk("ack_pulse", 32'({p0Ack, p1Ack}), 0);
    chk("idle_busy", 32'(arbBusy), 0);
  endtask

  initial begin
    int w, ac, prev, gap;
    for (int i = 0; i < 16; i++) init_mem[i] = 8'($urandom);
    init_mem[5] = 8'hA5;
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; wr[p] = 0; addr[p] = '0; wd[p] = '0;
    end
    mem_lat = 1;
    stuck = 0;
    do_reset();

    // Single read of a preloaded word
    req[0] = 1; wr[0] = 0; addr[0] = 32'd5;
    run_txn(1, 0, w, ac);
    chk("read_a5", 32'(p0RdData), 32'hA5);
    req[0] = 0;

    // Write then read back on port 1
    req[1] = 1; wr[1] = 1; addr[1] = 32'd9; wd[1] = 8'h3C;
    run_txn(1, 0, w, ac);
    wr[1] = 0;
    run_txn(1, 0, w, ac);
    chk("readback_3c", 32'(p1RdData), 32'h3C);
    req[1] = 0;

    // Both ports held from reset: alternating grants, 5 cycles per transaction
    req[0] = 1; req[1] = 1; wr[0] = 0; wr[1] = 0;
    addr[0] = $urandom; addr[1] = $urandom;
    do_reset();
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      run_txn(1, 0, w, ac);
      chk("cont_grant", 32'(arbGrant), k % 2);
      if (k > 0) chk("cont_spacing", 32'(ac - prev), 5);
      prev = ac;
    end
    req[0] = 0; req[1] = 0;

    // Randomised traffic with random latency and post-grant input scrambling
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p]) begin
          req[p] = 1'($urandom_range(0, 1)); wr[p] = 1'($urandom_range(0, 1));
          addr[p] = $urandom; wd[p] = 8'($urandom);
        end
      end
      if (!req[0] && !req[1]) req[$urandom_range(0, 1)] = 1;
      run_txn($urandom_range(1, 4), 1'($urandom_range(0, 1)), w, ac);
      req[w] = 0;
      if (!req[0] && !req[1]) begin
        gap = $urandom_range(0, 2);
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    req[0] = 0; req[1] = 0;
    repeat (3) @(posedge clk); #1;

    // Memory stuck busy: timeout forces the ack, error is sticky, next request still served
    req[1] = 1; wr[1] = 0; addr[1] = $urandom;
    stuck = 1;
    run_txn(1, 0, w, ac);
    stuck = 0;
    req[1] = 0;
    repeat (4) @(posedge clk); #1;
    req[0] = 1; wr[0] = 0; addr[0] = $urandom;
    run_txn(2, 0, w, ac);
    chk("timeout_sticky", 32'(timeoutErr), 1);
    req[0] = 0;

    // Reset while in WAIT: outputs clear at once, next tie goes to port 0
    req[0] = 1; wr[0] = 0; addr[0] = 32'd3; mem_lat = 4;
    ac = 0;
    do begin
      @(posedge clk); #1;
      ac++;
    end while (memReq !== 1'b1 && ac < 50);
    chk("midop_grant_seen", 32'(memReq), 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    #1;
    check_zero("midop");
    req[1] = 1; wr[1] = 0; addr[1] = 32'd7;
    do_reset();
    run_txn(1, 0, w, ac);
    chk("post_reset_tie", 32'(arbGrant), 0);
    req[0] = 0; req[1] = 0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
